// File: rtl/cr_xp10_decomp_lz77_hb_mc.sv
// XP10 decompressor LZ77 history buffer with multiple prefix banks.
// AG/user/payload-loader write arbitration, 2-cycle forwarded reads.
module cr_xp10_decomp_lz77_hb_mc #(
  parameter  int DATA_W    = 128,
  parameter  int HB_DEPTH  = 4096,
  parameter  int PFX_DEPTH = 64,
  parameter  int NUM_PFX   = 3,
  localparam int AW        = $clog2(HB_DEPTH),
  localparam int PAW       = $clog2(PFX_DEPTH),
  localparam int SW        = (NUM_PFX > 1) ? $clog2(NUM_PFX) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      ag_wr,
  input  logic [AW-1:0]             ag_waddr,
  input  logic [DATA_W-1:0]         ag_wdata,
  input  logic                      ag_rd,
  input  logic [AW-1:0]             ag_raddr,
  input  logic                      ag_eof,
  output logic                      rd_vld,
  output logic [DATA_W-1:0]         rd_data,
  input  logic [NUM_PFX-1:0]        pfx_in_use,
  input  logic [NUM_PFX-1:0]        pl_pfx_wr,
  input  logic [NUM_PFX*PAW-1:0]    pl_pfx_waddr,
  input  logic [NUM_PFX*DATA_W-1:0] pl_pfx_wdata,
  output logic [NUM_PFX-1:0]        pl_pfx_rdy,
  input  logic                      usr_wr,
  input  logic [DATA_W-1:0]         usr_wdata,
  output logic                      usr_rdy,
  output logic [AW-1:0]             usr_waddr,
  output logic                      usr_wrap
);

  localparam logic [AW-1:0] PFX_BASE = AW'(PFX_DEPTH);
  localparam logic [AW-1:0] HB_LAST  = AW'(HB_DEPTH - 1);

  logic [SW-1:0]             sel;
  logic                      pfx_act;
  logic                      ag_w_pfx;
  logic                      ag_r_pfx;
  logic                      ag_main_wr;
  logic                      usr_acc;
  logic                      main_we;
  logic [AW-1:0]             main_waddr;
  logic [DATA_W-1:0]         main_wdata;
  logic [DATA_W-1:0]         main_q;
  logic [NUM_PFX-1:0]        bk_ag_wr;
  logic [NUM_PFX-1:0]        bk_we;
  logic [NUM_PFX*PAW-1:0]    bk_waddr;
  logic [NUM_PFX*DATA_W-1:0] bk_wdata;
  logic [NUM_PFX*DATA_W-1:0] bk_q;
  logic                      fwd;
  logic [DATA_W-1:0]         fwd_data;
  logic                      p1_vld;
  logic                      p1_pfx;
  logic [SW-1:0]             p1_sel;
  logic                      p1_fwd;
  logic [DATA_W-1:0]         p1_fdata;
  logic [DATA_W-1:0]         bk_rsel;
  logic [DATA_W-1:0]         rd_next;
  logic [DATA_W-1:0]         main_mem [HB_DEPTH];

  // Active prefix bank: lowest set in-use flag
  always_comb begin
    sel     = '0;
    pfx_act = 1'b0;
    for (int i = NUM_PFX - 1; i >= 0; i--) begin
      if (pfx_in_use[i]) begin
        sel     = SW'(i);
        pfx_act = 1'b1;
      end
    end
  end

  assign ag_w_pfx   = pfx_act && (ag_waddr < PFX_BASE);
  assign ag_r_pfx   = pfx_act && (ag_raddr < PFX_BASE);
  assign ag_main_wr = ag_wr && !ag_w_pfx;

  assign usr_rdy    = !ag_main_wr;
  assign usr_acc    = usr_wr && usr_rdy;
  assign main_we    = ag_main_wr || usr_acc;
  assign main_waddr = ag_main_wr ? ag_waddr : usr_waddr;
  assign main_wdata = ag_main_wr ? ag_wdata : usr_wdata;

  // Main history RAM, synchronous read
  always_ff @(posedge clk) begin
    if (main_we) main_mem[main_waddr] <= main_wdata;
    if (ag_rd) main_q <= main_mem[ag_raddr];
  end

  for (genvar g = 0; g < NUM_PFX; g++) begin : g_bank
    logic [DATA_W-1:0] mem [PFX_DEPTH];
    logic [DATA_W-1:0] q;
    logic [PAW-1:0]    wa;
    logic [DATA_W-1:0] wd;

    assign bk_ag_wr[g]   = ag_wr && ag_w_pfx && (sel == SW'(g));
    assign pl_pfx_rdy[g] = !bk_ag_wr[g];
    assign bk_we[g]      = bk_ag_wr[g] || pl_pfx_wr[g];
    assign wa = bk_ag_wr[g] ? ag_waddr[PAW-1:0]
                            : pl_pfx_waddr[g*PAW +: PAW];
    assign wd = bk_ag_wr[g] ? ag_wdata
                            : pl_pfx_wdata[g*DATA_W +: DATA_W];
    assign bk_waddr[g*PAW +: PAW]       = wa;
    assign bk_wdata[g*DATA_W +: DATA_W] = wd;
    assign bk_q[g*DATA_W +: DATA_W]     = q;

    // Prefix bank RAM, synchronous read
    always_ff @(posedge clk) begin
      if (bk_we[g]) mem[wa] <= wd;
      if (ag_rd) q <= mem[ag_raddr[PAW-1:0]];
    end
  end

  // Same-cycle write to the read location wins over stored data
  always_comb begin
    fwd      = 1'b0;
    fwd_data = '0;
    if (ag_r_pfx) begin
      for (int i = 0; i < NUM_PFX; i++) begin
        if (sel == SW'(i) && bk_we[i] &&
            bk_waddr[i*PAW +: PAW] == ag_raddr[PAW-1:0]) begin
          fwd      = 1'b1;
          fwd_data = bk_wdata[i*DATA_W +: DATA_W];
        end
      end
    end else if (main_we && main_waddr == ag_raddr) begin
      fwd      = 1'b1;
      fwd_data = main_wdata;
    end
  end

  // Stage 1: tag the in-flight read with its source
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p1_vld   <= 1'b0;
      p1_pfx   <= 1'b0;
      p1_sel   <= '0;
      p1_fwd   <= 1'b0;
      p1_fdata <= '0;
    end else begin
      p1_vld <= ag_rd;
      if (ag_rd) begin
        p1_pfx   <= ag_r_pfx;
        p1_sel   <= sel;
        p1_fwd   <= fwd;
        p1_fdata <= fwd_data;
      end
    end
  end

  // Source mux for stage 2
  always_comb begin
    bk_rsel = '0;
    for (int i = 0; i < NUM_PFX; i++) begin
      if (p1_sel == SW'(i)) bk_rsel = bk_q[i*DATA_W +: DATA_W];
    end
    if (p1_fwd)      rd_next = p1_fdata;
    else if (p1_pfx) rd_next = bk_rsel;
    else             rd_next = main_q;
  end

  // Stage 2: present read data, hold when idle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_vld  <= 1'b0;
      rd_data <= '0;
    end else begin
      rd_vld <= p1_vld;
      if (p1_vld) rd_data <= rd_next;
    end
  end

  // User append pointer with EOF rewind and wrap pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      usr_waddr <= PFX_BASE;
      usr_wrap  <= 1'b0;
    end else begin
      usr_wrap <= 1'b0;
      if (ag_eof) begin
        usr_waddr <= PFX_BASE;
      end else if (usr_acc) begin
        if (usr_waddr == HB_LAST) begin
          usr_waddr <= PFX_BASE;
          usr_wrap  <= 1'b1;
        end else begin
          usr_waddr <= usr_waddr + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_cr_xp10_decomp_lz77_hb_mc.sv
// Bench for cr_xp10_decomp_lz77_hb_mc: random traffic vs array model.
// Small config: 128-word history, 64-word prefixes, 3 banks.
module tb_cr_xp10_decomp_lz77_hb_mc;

  localparam int DW = 32;
  localparam int HB = 128;
  localparam int PD = 64;
  localparam int NP = 3;
  localparam int AW = 7;
  localparam int PAW = 6;

  logic            clk = 1'b0;
  logic            rst;
  logic            ag_wr;
  logic [AW-1:0]   ag_waddr;
  logic [DW-1:0]   ag_wdata;
  logic            ag_rd;
  logic [AW-1:0]   ag_raddr;
  logic            ag_eof;
  logic            rd_vld;
  logic [DW-1:0]   rd_data;
  logic [NP-1:0]   pfx_in_use;
  logic [NP-1:0]   pl_pfx_wr;
  logic [NP*PAW-1:0] pl_pfx_waddr;
  logic [NP*DW-1:0]  pl_pfx_wdata;
  logic [NP-1:0]   pl_pfx_rdy;
  logic            usr_wr;
  logic [DW-1:0]   usr_wdata;
  logic            usr_rdy;
  logic [AW-1:0]   usr_waddr;
  logic            usr_wrap;

  cr_xp10_decomp_lz77_hb_mc #(
    .DATA_W(DW), .HB_DEPTH(HB), .PFX_DEPTH(PD), .NUM_PFX(NP)
  ) dut (
    .clk(clk), .rst(rst),
    .ag_wr(ag_wr), .ag_waddr(ag_waddr), .ag_wdata(ag_wdata),
    .ag_rd(ag_rd), .ag_raddr(ag_raddr), .ag_eof(ag_eof),
    .rd_vld(rd_vld), .rd_data(rd_data),
    .pfx_in_use(pfx_in_use), .pl_pfx_wr(pl_pfx_wr),
    .pl_pfx_waddr(pl_pfx_waddr), .pl_pfx_wdata(pl_pfx_wdata),
    .pl_pfx_rdy(pl_pfx_rdy),
    .usr_wr(usr_wr), .usr_wdata(usr_wdata), .usr_rdy(usr_rdy),
    .usr_waddr(usr_waddr), .usr_wrap(usr_wrap)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  logic [DW-1:0] main_m [HB];
  logic [DW-1:0] bank_m [NP][PD];
  int            m_ptr = PD;
  bit            m_acc;
  bit            pv;
  logic [DW-1:0] pd;
  logic [DW-1:0] e_data;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int sel_of(input logic [NP-1:0] piu);
    for (int b = 0; b < NP; b++) if (piu[b]) return b;
    return 0;
  endfunction

  task automatic idle();
    ag_wr = 0; ag_rd = 0; ag_eof = 0; usr_wr = 0;
    pl_pfx_wr = '0;
    ag_waddr = '0; ag_raddr = '0; ag_wdata = '0;
    pl_pfx_waddr = '0; pl_pfx_wdata = '0; usr_wdata = '0;
  endtask

  // One clock: check handshakes, update model, then check read side
  task automatic cycle();
    int s;
    bit ag_pfx, ag_main, r_pfx, wrap_n;
    logic [NP-1:0] erdy;
    logic [DW-1:0] rv;
    #1;
    s = sel_of(pfx_in_use);
    ag_pfx  = ag_wr && pfx_in_use != 0 && int'(ag_waddr) < PD;
    ag_main = ag_wr && !ag_pfx;
    m_acc   = usr_wr && !ag_main;
    for (int b = 0; b < NP; b++) erdy[b] = !(ag_pfx && s == b);
    chk("usr_rdy", 64'(usr_rdy), 64'(!ag_main));
    chk("pfx_rdy", 64'(pl_pfx_rdy), 64'(erdy));
    chk("usr_waddr", 64'(usr_waddr), 64'(m_ptr));
    if (m_acc) main_m[m_ptr] = usr_wdata;
    if (ag_main) main_m[ag_waddr] = ag_wdata;
    for (int b = 0; b < NP; b++)
      if (pl_pfx_wr[b] && erdy[b])
        bank_m[b][pl_pfx_waddr[b*PAW +: PAW]] = pl_pfx_wdata[b*DW +: DW];
    if (ag_pfx) bank_m[s][ag_waddr[PAW-1:0]] = ag_wdata;
    r_pfx = pfx_in_use != 0 && int'(ag_raddr) < PD;
    rv = r_pfx ? bank_m[s][ag_raddr[PAW-1:0]] : main_m[ag_raddr];
    wrap_n = 0;
    if (ag_eof) m_ptr = PD;
    else if (m_acc) begin
      if (m_ptr == HB - 1) begin m_ptr = PD; wrap_n = 1; end
      else m_ptr++;
    end
    @(posedge clk);
    #1;
    if (pv) e_data = pd;
    chk("rd_vld", 64'(rd_vld), 64'(pv));
    chk("rd_data", 64'(rd_data), 64'(e_data));
    chk("usr_wrap", 64'(usr_wrap), 64'(wrap_n));
    pv = ag_rd;
    pd = rv;
  endtask

  initial begin
    logic [DW-1:0] d, old;
    int wraps, vcnt;
    idle();
    pfx_in_use = '0;
    rst = 1;
    pv = 0; e_data = '0; pd = '0;
    #12;
    chk("rst_vld", 64'(rd_vld), 64'd0);
    chk("rst_data", 64'(rd_data), 64'd0);
    chk("rst_ptr", 64'(usr_waddr), 64'(PD));
    chk("rst_wrap", 64'(usr_wrap), 64'd0);
    chk("rst_urdy", 64'(usr_rdy), 64'd1);
    chk("rst_prdy", 64'(pl_pfx_rdy), 64'h7);
    @(posedge clk); #1;
    rst = 0;

    for (int a = 0; a < HB; a++) begin
      idle(); ag_wr = 1; ag_waddr = AW'(a); ag_wdata = $urandom;
      cycle();
    end
    for (int b = 0; b < NP; b++)
      for (int a = 0; a < PD; a++) begin
        idle(); pfx_in_use = NP'(1 << b);
        ag_wr = 1; ag_waddr = AW'(a); ag_wdata = $urandom;
        cycle();
      end

    // prefix routing to bank 1
    idle(); pfx_in_use = 3'b110;
    ag_wr = 1; ag_waddr = 7'd5; ag_wdata = 32'hA5A5_A5A5;
    cycle();
    idle(); ag_rd = 1; ag_raddr = 7'd5; cycle();
    idle(); cycle();
    chk("pfx_vld", 64'(rd_vld), 64'd1);
    chk("pfx_route", 64'(rd_data), 64'hA5A5_A5A5);
    old = main_m[5];
    idle(); pfx_in_use = '0; ag_rd = 1; ag_raddr = 7'd5; cycle();
    idle(); cycle();
    chk("main_keep", 64'(rd_data), 64'(old));

    // arbitration stall
    idle(); ag_eof = 1; cycle();
    chk("eof_ptr", 64'(usr_waddr), 64'(PD));
    d = $urandom;
    idle(); usr_wr = 1; usr_wdata = d;
    ag_wr = 1; ag_waddr = 7'h50; ag_wdata = $urandom;
    for (int k = 0; k < 3; k++) begin
      #1 chk("stall_rdy", 64'(usr_rdy), 64'd0);
      cycle();
    end
    ag_wr = 0; cycle();
    chk("stall_ptr", 64'(usr_waddr), 64'd65);
    idle(); ag_rd = 1; ag_raddr = 7'd64; cycle();
    idle(); cycle();
    chk("stall_data", 64'(rd_data), 64'(d));

    // collision forwarding and later-write isolation
    idle(); ag_rd = 1; ag_raddr = 7'd65;
    usr_wr = 1; usr_wdata = 32'h1234; cycle();
    idle(); cycle();
    chk("fwd_data", 64'(rd_data), 64'h1234);
    old = main_m[66];
    idle(); ag_rd = 1; ag_raddr = 7'd66; cycle();
    idle(); usr_wr = 1; usr_wdata = 32'h5678; cycle();
    chk("late_wr", 64'(rd_data), 64'(old));

    // wrap
    idle(); ag_eof = 1; cycle();
    wraps = 0;
    for (int k = 0; k < HB - PD; k++) begin
      idle(); usr_wr = 1; usr_wdata = $urandom; cycle();
      wraps += int'(usr_wrap);
    end
    chk("wrap_cnt", 64'(wraps), 64'd1);
    chk("wrap_ptr", 64'(usr_waddr), 64'(PD));

    // EOF with concurrent accepted write
    for (int k = 0; k < 3; k++) begin
      idle(); usr_wr = 1; usr_wdata = $urandom; cycle();
    end
    d = $urandom;
    idle(); usr_wr = 1; usr_wdata = d; ag_eof = 1; cycle();
    chk("eofw_ptr", 64'(usr_waddr), 64'(PD));
    idle(); ag_rd = 1; ag_raddr = 7'd67; cycle();
    idle(); cycle();
    chk("eofw_data", 64'(rd_data), 64'(d));

    // streaming across prefix/main boundary
    vcnt = 0;
    for (int a = 60; a < 76; a++) begin
      idle(); pfx_in_use = 3'b001; ag_rd = 1; ag_raddr = AW'(a);
      cycle();
      vcnt += int'(rd_vld);
    end
    idle(); cycle();
    vcnt += int'(rd_vld);
    chk("stream_cnt", 64'(vcnt), 64'd16);

    // reset with a read in flight
    idle(); ag_rd = 1; ag_raddr = 7'd10; cycle();
    idle(); rst = 1;
    #2;
    chk("mid_vld", 64'(rd_vld), 64'd0);
    chk("mid_data", 64'(rd_data), 64'd0);
    chk("mid_ptr", 64'(usr_waddr), 64'(PD));
    chk("mid_wrap", 64'(usr_wrap), 64'd0);
    pv = 0; e_data = '0; m_ptr = PD;
    rst = 0;
    for (int k = 0; k < 3; k++) cycle();

    // random traffic
    m_acc = 1;
    for (int n = 0; n < 3000; n++) begin
      bit hold;
      logic [DW-1:0] hd;
      int r;
      hold = usr_wr && !m_acc;
      hd = usr_wdata;
      idle();
      pfx_in_use = NP'($urandom);
      ag_wr = ($urandom_range(0, 2) == 0);
      ag_waddr = AW'($urandom);
      ag_wdata = $urandom;
      ag_eof = ($urandom_range(0, 31) == 0);
      pl_pfx_wr = NP'($urandom);
      for (int b = 0; b < NP; b++) begin
        pl_pfx_waddr[b*PAW +: PAW] = PAW'($urandom);
        pl_pfx_wdata[b*DW +: DW] = $urandom;
      end
      if (hold) begin usr_wr = 1; usr_wdata = hd; end
      else begin usr_wr = $urandom_range(0, 1) == 1; usr_wdata = $urandom; end
      ag_rd = $urandom_range(0, 3) != 0;
      r = $urandom_range(0, 7);
      if (r < 2) ag_raddr = ag_waddr;
      else if (r < 4) ag_raddr = AW'(m_ptr);
      else if (r < 5)
        ag_raddr = AW'(pl_pfx_waddr[sel_of(pfx_in_use)*PAW +: PAW]);
      else ag_raddr = AW'($urandom);
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/cr_xp10_decomp_lz77_hb_mc.md
Name: cr_xp10_decomp_lz77_hb_mc

Overview:
Parametrised multi-prefix LZ77 history buffer for the XP10 decompressor. It holds a main history RAM plus NUM_PFX prefix banks, and routes address-generator (AG) reads and writes to the active prefix bank or to the main RAM. It generates the user-data append address internally and exerts ready backpressure on displaced writers. Same-cycle read/write collisions are forwarded, giving a fixed, valid-qualified read latency.

Parameters:
DATA_W, 128, data word width in bits.
HB_DEPTH, 4096, main history words (power of 2); AW = log2(HB_DEPTH).
PFX_DEPTH, 64, words per prefix bank (power of 2, < HB_DEPTH); PAW = log2(PFX_DEPTH).
NUM_PFX, 3, number of prefix banks (1..8).

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
ag_wr  in  1  AG write strobe
ag_waddr  in  AW  AG write address
ag_wdata  in  DATA_W  AG write data
ag_rd  in  1  AG read strobe
ag_raddr  in  AW  AG read address
ag_eof  in  1  end of frame; rewinds user append pointer
rd_vld  out  1  read data valid, 2 cycles after ag_rd
rd_data  out  DATA_W  read data
pfx_in_use  in  NUM_PFX  prefix bank active flags
pl_pfx_wr  in  NUM_PFX  payload-loader prefix write valid, one per bank
pl_pfx_waddr  in  NUM_PFX*PAW  per-bank write address, bank i at [i*PAW +: PAW]
pl_pfx_wdata  in  NUM_PFX*DATA_W  per-bank write data
pl_pfx_rdy  out  NUM_PFX  per-bank write accepted
usr_wr  in  1  user append write valid
usr_wdata  in  DATA_W  user append data
usr_rdy  out  1  user write accepted
usr_waddr  out  AW  current append address
usr_wrap  out  1  one-cycle pulse when the append pointer wraps

Behaviour:
- Bank select: sel = lowest index i with pfx_in_use[i] = 1; none set means no prefix active.
- AG target: address < PFX_DEPTH and a prefix is active selects bank sel at address[PAW-1:0]. Otherwise the main RAM at the full address. The same rule applies to reads and writes.
- Main RAM write port priority: an AG write targeting main beats usr_wr.
  - usr_rdy = !(ag_wr && AG target is main). This is combinational.
  - The user handshake completes on usr_wr && usr_rdy, writing usr_wdata at usr_waddr.
  - usr_wr held while usr_rdy = 0 must keep its data stable; no write occurs until accepted.
- Prefix bank i write port priority: an AG write targeting bank i beats pl_pfx_wr[i].
  - pl_pfx_rdy[i] = !(ag_wr && AG target is bank i).
- Append pointer (usr_waddr):
  - Resets to PFX_DEPTH.
  - ag_eof sets it to PFX_DEPTH, and has priority over an accepted write in the same cycle; that write still lands at the old address.
  - An accepted write increments it. At HB_DEPTH-1 it wraps to PFX_DEPTH and pulses usr_wrap for 1 cycle.
- Read pipeline:
  - Cycle 0: ag_rd is sampled and the RAM read is issued.
  - Cycle 1: RAM data is registered along with a target tag.
  - Cycle 2: rd_vld = 1 and rd_data is presented.
  - Back-to-back reads are supported every cycle with no bubbles.
  - rd_data holds its last value when rd_vld = 0.
- Collision forwarding: a read and a write to the same physical location (same bank/main, same address) in the same cycle return the write data. This covers AG, user and payload-loader writes, whichever wins arbitration. Storage read-during-write output is never used.
- A write in a later cycle than a read never affects that read's data.
- Reset (async, any time):
  - rd_vld = 0, rd_data = 0, usr_waddr = PFX_DEPTH, usr_wrap = 0.
  - Pipeline tags are cleared; in-flight reads are dropped and no rd_vld follows.
  - RAM contents are not cleared.
- usr_rdy and pl_pfx_rdy follow their combinational equations during reset (all 1 when ag_wr = 0).
- Storage is inferred simple dual-port arrays: one main RAM and NUM_PFX prefix banks, synchronous read, 1-cycle latency.
- Widths: all address compares are unsigned at AW bits; PAW-bit truncation applies only to prefix targets.

Test Plan:
- Prefix routing: pfx_in_use = 3'b110; AG write 0xA5.. to addr 5; AG read addr 5 -> writes land in bank 1 only. Read returns 0xA5.. with rd_vld exactly 2 cycles later; main RAM addr 5 is unchanged (verify via read with pfx_in_use = 0).
- Arbitration stall: usr_wr held with data D while ag_wr hits main addr 0x100 for 3 cycles -> usr_rdy = 0 for those 3 cycles. D is then written at usr_waddr = 64 on the 4th cycle and usr_waddr becomes 65.
- Wrap and EOF, with HB_DEPTH = 128 and PFX_DEPTH = 64:
  - 64 accepted user writes -> usr_waddr 64..127 then back to 64, with usr_wrap pulsing once.
  - ag_eof concurrent with an accepted write -> write lands at the old address; pointer = 64.
- Collision forwarding: same-cycle AG read addr 0x200 with accepted user write to 0x200 (data 0x1234) -> rd_data = 0x1234. A write to 0x200 one cycle after the read -> old data is returned.
- Streaming reads: 16 consecutive ag_rd across prefix/main boundary addresses 60..75 with pfx_in_use = 1 -> 16 consecutive rd_vld cycles in order with correct sources.
- Reset mid-flight: assert rst one cycle after ag_rd -> no rd_vld thereafter; outputs at reset values; usr_waddr = PFX_DEPTH.
